// File: rtl/mem_port_arbiter_if.sv
// Requester and memory handshake bundle for mem_port_arbiter.
// slave = arbiter view; master = requesters plus memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [LEN_W-1:0]  i_len;
    logic              i_addr_ok;
    logic              i_data_ok;
    logic              i_data_last;
    logic [DATA_W-1:0] i_rdata;

    logic                d_req;
    logic                d_wr;
    logic [ADDR_W-1:0]   d_addr;
    logic [LEN_W-1:0]    d_len;
    logic [DATA_W/8-1:0] d_wstrb;
    logic [DATA_W-1:0]   d_wdata;
    logic                d_addr_ok;
    logic                d_data_ok;
    logic                d_data_last;
    logic [DATA_W-1:0]   d_rdata;

    logic                mem_req;
    logic                mem_wr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [LEN_W-1:0]    mem_len;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_addr_ok;
    logic                mem_data_ok;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  i_req, i_addr, i_len,
        output i_addr_ok, i_data_ok, i_data_last, i_rdata,
        input  d_req, d_wr, d_addr, d_len, d_wstrb, d_wdata,
        output d_addr_ok, d_data_ok, d_data_last, d_rdata,
        output mem_req, mem_wr, mem_addr, mem_len, mem_wstrb, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output i_req, i_addr, i_len,
        input  i_addr_ok, i_data_ok, i_data_last, i_rdata,
        output d_req, d_wr, d_addr, d_len, d_wstrb, d_wdata,
        input  d_addr_ok, d_data_ok, d_data_last, d_rdata,
        input  mem_req, mem_wr, mem_addr, mem_len, mem_wstrb, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Burst arbiter sharing one memory port between I-cache and D-cache miss paths.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests (default: data first).
//
//  state    | meaning
//  IDLE     | port free, arbitration evaluated
//  I_ADDR   | inst address phase offered to memory
//  I_DATA   | inst read beats in flight, cnt = beats left - 1
//  D_ADDR   | data address phase offered to memory
//  D_DATA   | data read/write beats in flight, cnt = beats left - 1
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                grant_d
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_I_ADDR,
        S_I_DATA,
        S_D_ADDR,
        S_D_DATA
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             pick_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;
    assign pick_i = last_d_q;
`else
    assign pick_i = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d        = last_d_q;
`endif
        bus.i_addr_ok   = 1'b0;
        bus.i_data_ok   = 1'b0;
        bus.i_data_last = 1'b0;
        bus.i_rdata     = '0;
        bus.d_addr_ok   = 1'b0;
        bus.d_data_ok   = 1'b0;
        bus.d_data_last = 1'b0;
        bus.d_rdata     = '0;
        bus.mem_req     = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_len     = '0;
        bus.mem_wstrb   = '0;
        bus.mem_wdata   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.d_req && !(bus.i_req && pick_i)) begin
                    state_d = S_D_ADDR;
                end else if (bus.i_req) begin
                    state_d = S_I_ADDR;
                end
            end
            S_I_ADDR: begin
                bus.mem_req  = bus.i_req;
                bus.mem_addr = bus.i_addr;
                bus.mem_len  = bus.i_len;
                if (!bus.i_req) begin
                    state_d = S_IDLE;
                end else if (bus.mem_addr_ok) begin
                    bus.i_addr_ok = 1'b1;
                    cnt_d         = bus.i_len;
                    state_d       = S_I_DATA;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d      = 1'b0;
`endif
                end
            end
            S_I_DATA: begin
                bus.i_data_ok = bus.mem_data_ok;
                bus.i_rdata   = bus.mem_rdata;
                if (bus.mem_data_ok) begin
                    if (cnt_q == '0) begin
                        bus.i_data_last = 1'b1;
                        state_d         = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_D_ADDR: begin
                bus.mem_req   = bus.d_req;
                bus.mem_wr    = bus.d_wr;
                bus.mem_addr  = bus.d_addr;
                bus.mem_len   = bus.d_len;
                bus.mem_wstrb = bus.d_wr ? bus.d_wstrb : '0;
                if (!bus.d_req) begin
                    state_d = S_IDLE;
                end else if (bus.mem_addr_ok) begin
                    bus.d_addr_ok = 1'b1;
                    cnt_d         = bus.d_len;
                    state_d       = S_D_DATA;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d      = 1'b1;
`endif
                end
            end
            S_D_DATA: begin
                // write data follows the requester, which advances on each d_data_ok
                bus.mem_wr    = bus.d_wr;
                bus.mem_wstrb = bus.d_wr ? bus.d_wstrb : '0;
                bus.mem_wdata = bus.d_wdata;
                bus.d_data_ok = bus.mem_data_ok;
                bus.d_rdata   = bus.mem_rdata;
                if (bus.mem_data_ok) begin
                    if (cnt_q == '0) begin
                        bus.d_data_last = 1'b1;
                        state_d         = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign grant_d = (state_q == S_D_ADDR) || (state_q == S_D_DATA);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one SRAM-like memory port between the I-cache miss path and the D-cache miss/writeback path.
- Sits below the MMU, between the physical-address cache controllers and the single external memory/bridge port.
- Grants one requester at a time for a full burst transaction (address phase + N data beats), then releases.
- Default priority is fixed, data over instruction; a compile option selects round-robin.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
LEN_W, 4, burst length field width; beats = len+1 (1..16)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_req  in  1  inst requester request (read only); held until i_addr_ok or abandoned
i_addr  in  ADDR_W  inst physical address
i_len  in  LEN_W  inst burst length minus 1
i_addr_ok  out  1  inst request accepted (1-cycle pulse)
i_data_ok  out  1  inst read beat valid
i_data_last  out  1  final inst beat
i_rdata  out  DATA_W  inst read data
d_req  in  1  data requester request
d_wr  in  1  1=write, 0=read
d_addr  in  ADDR_W  data physical address
d_len  in  LEN_W  data burst length minus 1
d_wstrb  in  DATA_W/8  byte strobes
d_wdata  in  DATA_W  current write beat; requester advances on d_data_ok
d_addr_ok  out  1  data request accepted
d_data_ok  out  1  data beat done (read valid / write consumed)
d_data_last  out  1  final data beat
d_rdata  out  DATA_W  data read data
mem_req  out  1  memory request
mem_wr  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_len  out  LEN_W  memory burst length
mem_wstrb  out  DATA_W/8  memory strobes
mem_wdata  out  DATA_W  memory write data
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory beat done
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE
grant_d  out  1  data side owns the port (I_ADDR/I_DATA → 0)

Behaviour:
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA. One registered beat counter cnt[LEN_W-1:0].
- Reset (synchronous, active-high): state=IDLE, cnt=0. All outputs 0, since the mem_* and requester muxes are gated by state.
- IDLE:
  - d_req → D_ADDR; else i_req → I_ADDR; else stay.
  - The decision is registered, so mem_req rises 1 cycle after the requester's req.
- X_ADDR:
  - mem_req = x_req. mem_addr/len/wr/wstrb come combinationally from requester X; mem_wr=0 for inst.
  - mem_req & mem_addr_ok → x_addr_ok pulse in the same cycle, cnt <= x_len, go to X_DATA.
  - x_req low before accept (abandon) → IDLE, no memory transaction.
- X_DATA:
  - mem_req=0. mem_wdata=d_wdata and mem_wstrb=d_wstrb (wstrb in data writes only).
  - x_data_ok = mem_data_ok; x_rdata = mem_rdata.
  - Each mem_data_ok with cnt≠0 → cnt decrements.
  - mem_data_ok with cnt==0 → x_data_last=1 in the same cycle, then IDLE.
  - Requester req is ignored during X_DATA.
- Unselected requester: addr_ok/data_ok/data_last = 0; its rdata is driven 0.
- mem_addr_ok or mem_data_ok in an unexpected state (IDLE, or addr_ok in X_DATA) is ignored. No state change, no pulse forwarded.
- Turnaround: last beat → IDLE → next grant. Minimum of 1 idle cycle with mem_req=0 between transactions.
- Simultaneous i_req & d_req in IDLE: data wins (fixed mode). The loser stays pending and is granted in the next IDLE evaluation if still asserted.
- Reset mid-burst: immediate return to IDLE. The outstanding memory transaction is discarded; the memory side is reset with the same rst.
- len=0: single beat. The first mem_data_ok is the last beat.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Adds register last_d (reset 0), set to 1 on each D_ADDR accept and to 0 on each I_ADDR accept.
  - On simultaneous requests in IDLE, grant inst if last_d=1, else data.
  - A single requester is always granted.
- Undefined: fixed data-over-inst priority; no last_d register.

Test Plan:
- i_req only, i_addr=0x1FC0_0000, i_len=3; mem_addr_ok 2 cycles after mem_req; 4 mem_data_ok beats (0xA0..0xA3) → mem_req rises 1 cycle after i_req; i_addr_ok pulses with mem_addr_ok; i_rdata = A0..A3; i_data_last on the 4th beat; busy drops the next cycle.
- d_req write, d_len=0, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 → mem_wr=1; mem_wdata=0xDEADBEEF and mem_wstrb=0011 on the data beat; d_data_last=1 on the first mem_data_ok.
- i_req and d_req asserted in the same cycle, fixed mode → data burst completes, 1 idle cycle follows, then inst is granted. i_addr_ok is never asserted during the data transaction.
- ARB_ROUND_ROBIN_EN, both requesters continuously requesting with len=0 → grants alternate D, I, D, I.
- i_req dropped in I_ADDR before mem_addr_ok → mem_req falls the same cycle; state returns to IDLE; i_addr_ok never pulses.
- rst asserted during the 2nd of 4 beats → next cycle busy=0, mem_req=0, all *_ok=0; stray mem_data_ok afterwards is ignored.
